mem_load_stage: RTL
===================

# mem_load_stage

Parametrised MEM pipeline stage for the AXI core. It registers the DC→MEM bundle and holds it across stalls. A BUF_DEPTH-entry read-data FIFO captures every `rdata_valid` beat that arrives while the stage is stalled. The stage formats loads (byte, half and word, plus the unaligned LWL/LWR pair) and prioritises exceptions into the 32-bit excepttype consumed by WB/CP0.

## Interface
Parameters:
- `SIDE_W`, 38: width of the opaque sideband (cp0 bus) passed unchanged to WB.
- `BUF_DEPTH`, 2: read-data capture FIFO depth. Legal values are 1–4.
- `EXC_W`, 32: width of the upstream exception bit-vector.

Ports (reset is synchronous, active-high; one clock):
- `clk` in 1: core clock.
- `rst` in 1: synchronous active-high reset.
- `flush` in 1: exception flush.
- `stall_cur` in 1: this stage is held.
- `stall_nxt` in 1: WB is held.
- `in_valid` in 1: DC slot holds an instruction.
- `in_pc` in 32: instruction PC.
- `in_op` in 3: load op (`LOP_*`).
- `in_sel_mem` in 1: writeback selects the load result.
- `in_we` in 1: register write enable.
- `in_waddr` in 5: destination register.
- `in_alu` in 32: ALU result / effective address.
- `in_rt` in 32: old rt value, used for the LWL/LWR merge.
- `in_exc` in EXC_W: exception flags.
- `in_dslot` in 1: instruction is in a delay slot.
- `in_badva` in 32: bad virtual address.
- `in_side` in SIDE_W: sideband.
- `rdata` in 32: data bus read data.
- `rdata_valid` in 1: read-data beat.
- `cp0_status` in 32, `cp0_cause` in 32, `cp0_epc` in 32.
- `out_valid` out 1.
- `out_pc` out 32.
- `out_we` out 1 (= registered `in_we & valid`).
- `out_waddr` out 5.
- `out_wdata` out 32.
- `out_data_ok` out 1: registered rdata was present.
- `out_excepttype` out 32.
- `out_epc` out 32.
- `out_dslot` out 1.
- `out_badva` out 32.
- `out_side` out SIDE_W.
- `buf_ovf` out 1: sticky FIFO overflow.

## Operation
- **Stage register update**, priority order:
  1. `rst`
  2. `flush`
  3. `stall_cur & ~stall_nxt`: insert a bubble (all fields 0).
  4. `~stall_cur`: advance.
  5. Otherwise hold.
- **On advance**, the captured data word is chosen as:
  - the FIFO head, if the FIFO is non-empty. This pops the FIFO and sets `data_ok=1`.
  - otherwise live `rdata`, with `data_ok=rdata_valid`.
- **FIFO push:** `rdata_valid & stall_cur & ~flush`.
  - Simultaneous push and pop on a non-empty FIFO is legal; the count is unchanged.
  - A push when full drops the beat and sets `buf_ovf`. `buf_ovf` clears only on `rst`.
  - `flush` empties the FIFO.
- **Load formatting** is combinational from the registered word `d`, using `a` = `alu[1:0]`:
  - LB/LBU: byte `a`, sign- or zero-extended.
  - LH/LHU: `a`=0 selects `d[15:0]`, `a`=2 selects `d[31:16]`; odd `a` gives 0.
  - LW: `d` when `a`=0, else 0.
  - LWL, by `a` = 0/1/2/3: `{d[7:0],rt[23:0]}`, `{d[15:0],rt[15:0]}`, `{d[23:0],rt[7:0]}`, `d`.
  - LWR, by `a` = 0/1/2/3: `d`, `{rt[31:24],d[31:8]}`, `{rt[31:16],d[31:16]}`, `{rt[31:8],d[31:24]}`.
  - `LOP_NONE` gives 0.
  - `out_wdata` = `sel_mem` ? formatted : `alu`.
- **Exception encode:** only when `valid` and `pc != 0`; otherwise 0. First match wins:
  - interrupt → 0x01. Condition: `(cause[15:8]&status[15:8])!=0 && status[1]==0 && status[0]==1`.
  - syscall [8] → 0x08
  - break [13] → 0x09
  - RI [9] → 0x0a
  - trap [10] → 0x0d
  - ov [11] → 0x0c
  - eret [12] → 0x0e
  - AdES [14] → 0x05
  - AdEL [15] → 0x04
  - fetch AdEL [16] → 0x04
- **EPC:** `out_epc` = `cp0_epc`, passed through combinationally.

## Timing
- Latency: inputs accepted on an advance edge appear on `out_*` in the next cycle.
- Formatting, `out_epc` and `out_excepttype` are combinational from the stage register and CP0 inputs; the stage adds no extra cycle.
- Reset state: all stage fields 0, FIFO empty, `buf_ovf`=0. Consequently every `out_*` is 0 after reset, except `out_epc`, which follows `cp0_epc`.
- `flush` in the same cycle as a push: the flush wins and the beat is dropped with no overflow.
- `rst` in mid-stall discards FIFO contents immediately.
- BUF_DEPTH=1: the FIFO is full after one push; a second stalled beat overflows.

## Structure
- Package `mem_pkg`:
  - `LOP_NONE`, `LOP_LB`, `LOP_LBU`, `LOP_LH`, `LOP_LHU`, `LOP_LW`, `LOP_LWL`, `LOP_LWR` (3-bit).
  - Exception bit indices (8–16).
  - Excepttype constants.
- Sub-module `rdata_fifo`: BUF_DEPTH circular buffer with wrapping read/write pointers, a count, push/pop/flush, and overflow detection.
- Load formatter and exception encoder stay inline.

## Test plan
- LB at `alu`=0x...3, `rdata`=0x80_11_22_33 → `out_wdata`=0xFFFFFF80. The same case with LBU → 0x00000080.
- LWL `a`=1, `rt`=0xAABBCCDD, `rdata`=0x11223344 → 0x3344CCDD. LWR `a`=2 with the same data → 0xAABB1122.
- Stall 3 cycles with BUF_DEPTH=2 and beats 0xA, 0xB on stalled cycles, then release → WB sees 0xA with `data_ok`=1. The next advance pops 0xB; the FIFO ends empty. A third stalled beat sets `buf_ovf`.
- `stall_cur=1`, `stall_nxt=0` → `out_valid`=0 and `out_we`=0 next cycle. `flush` during a push → FIFO empty and `buf_ovf` unchanged.
- Exception priority:
  - `in_exc` bits 8 and 15 set → 0x08.
  - Interrupt pending (`status`=0x0401, `cause`=0x0400) at the same time → 0x01.
  - `pc`=0 → 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: load opcodes, upstream exception bit
// positions and the excepttype codes handed to WB/CP0.
package mem_pkg;

  localparam logic [2:0] LOP_NONE = 3'd0;
  localparam logic [2:0] LOP_LB   = 3'd1;
  localparam logic [2:0] LOP_LBU  = 3'd2;
  localparam logic [2:0] LOP_LH   = 3'd3;
  localparam logic [2:0] LOP_LHU  = 3'd4;
  localparam logic [2:0] LOP_LW   = 3'd5;
  localparam logic [2:0] LOP_LWL  = 3'd6;
  localparam logic [2:0] LOP_LWR  = 3'd7;

  localparam int unsigned EXC_SYSCALL  = 8;
  localparam int unsigned EXC_RI       = 9;
  localparam int unsigned EXC_TRAP     = 10;
  localparam int unsigned EXC_OV       = 11;
  localparam int unsigned EXC_ERET     = 12;
  localparam int unsigned EXC_BREAK    = 13;
  localparam int unsigned EXC_ADES     = 14;
  localparam int unsigned EXC_ADEL     = 15;
  localparam int unsigned EXC_IF_ADEL  = 16;

  localparam logic [31:0] ET_INT     = 32'h0000_0001;
  localparam logic [31:0] ET_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] ET_BREAK   = 32'h0000_0009;
  localparam logic [31:0] ET_RI      = 32'h0000_000a;
  localparam logic [31:0] ET_TRAP    = 32'h0000_000d;
  localparam logic [31:0] ET_OV      = 32'h0000_000c;
  localparam logic [31:0] ET_ERET    = 32'h0000_000e;
  localparam logic [31:0] ET_ADES    = 32'h0000_0005;
  localparam logic [31:0] ET_ADEL    = 32'h0000_0004;

endpackage

// File: rtl/mem_load_stage_rdata_fifo.sv
// Circular capture buffer for read-data beats that arrive while MEM is held.
// Sticky overflow flag; flush empties the buffer and suppresses the push.
module rdata_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] head,
  output logic        empty,
  output logic        ovf
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_pop, do_push;

  // A pop in the same cycle frees a slot, so a push on a full buffer is kept.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != FULL) | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (push && !do_push)
        ovf_d = 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;

endmodule

// File: rtl/mem_load_stage.sv
// MEM pipeline stage: registers the DC->MEM bundle, captures stalled read
// beats, formats loads and encodes the prioritised excepttype for WB/CP0.
module mem_load_stage
  import mem_pkg::*;
#(
  parameter int unsigned SIDE_W    = 38,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned EXC_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_cur,
  input  logic              stall_nxt,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [2:0]        in_op,
  input  logic              in_sel_mem,
  input  logic              in_we,
  input  logic [4:0]        in_waddr,
  input  logic [31:0]       in_alu,
  input  logic [31:0]       in_rt,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_dslot,
  input  logic [31:0]       in_badva,
  input  logic [SIDE_W-1:0] in_side,
  input  logic [31:0]       rdata,
  input  logic              rdata_valid,
  input  logic [31:0]       cp0_status,
  input  logic [31:0]       cp0_cause,
  input  logic [31:0]       cp0_epc,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic              out_we,
  output logic [4:0]        out_waddr,
  output logic [31:0]       out_wdata,
  output logic              out_data_ok,
  output logic [31:0]       out_excepttype,
  output logic [31:0]       out_epc,
  output logic              out_dslot,
  output logic [31:0]       out_badva,
  output logic [SIDE_W-1:0] out_side,
  output logic              buf_ovf
);

  logic              valid_q, valid_d, sel_mem_q, sel_mem_d, we_q, we_d;
  logic              dslot_q, dslot_d, data_ok_q, data_ok_d;
  logic [31:0]       pc_q, pc_d, alu_q, alu_d, rt_q, rt_d;
  logic [31:0]       badva_q, badva_d, data_q, data_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic [SIDE_W-1:0] side_q, side_d;

  logic [31:0] fifo_head;
  logic        fifo_empty;

  rdata_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (rdata_valid & stall_cur & ~flush),
    .pop   (~flush & ~stall_cur),
    .wdata (rdata),
    .head  (fifo_head),
    .empty (fifo_empty),
    .ovf   (buf_ovf)
  );

  always_comb begin
    valid_d = valid_q;  pc_d    = pc_q;    op_d    = op_q;    sel_mem_d = sel_mem_q;
    we_d    = we_q;     waddr_d = waddr_q; alu_d   = alu_q;   rt_d      = rt_q;
    exc_d   = exc_q;    dslot_d = dslot_q; badva_d = badva_q; side_d    = side_q;
    data_d  = data_q;   data_ok_d = data_ok_q;
    if (flush || (stall_cur && !stall_nxt)) begin
      valid_d = 1'b0;  pc_d    = '0;   op_d    = '0;   sel_mem_d = 1'b0;
      we_d    = 1'b0;  waddr_d = '0;   alu_d   = '0;   rt_d      = '0;
      exc_d   = '0;    dslot_d = 1'b0; badva_d = '0;   side_d    = '0;
      data_d  = '0;    data_ok_d = 1'b0;
    end else if (!stall_cur) begin
      valid_d = in_valid;  pc_d    = in_pc;    op_d    = in_op;    sel_mem_d = in_sel_mem;
      we_d    = in_we & in_valid;  waddr_d = in_waddr;  alu_d = in_alu;  rt_d = in_rt;
      exc_d   = in_exc;    dslot_d = in_dslot; badva_d = in_badva; side_d    = in_side;
      // Beats buffered during the stall are older than the live bus word.
      data_d    = fifo_empty ? rdata : fifo_head;
      data_ok_d = ~fifo_empty | rdata_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;  pc_q    <= '0;   op_q    <= '0;   sel_mem_q <= 1'b0;
      we_q    <= 1'b0;  waddr_q <= '0;   alu_q   <= '0;   rt_q      <= '0;
      exc_q   <= '0;    dslot_q <= 1'b0; badva_q <= '0;   side_q    <= '0;
      data_q  <= '0;    data_ok_q <= 1'b0;
    end else begin
      valid_q <= valid_d;  pc_q    <= pc_d;    op_q    <= op_d;    sel_mem_q <= sel_mem_d;
      we_q    <= we_d;     waddr_q <= waddr_d; alu_q   <= alu_d;   rt_q      <= rt_d;
      exc_q   <= exc_d;    dslot_q <= dslot_d; badva_q <= badva_d; side_q    <= side_d;
      data_q  <= data_d;   data_ok_q <= data_ok_d;
    end
  end

  logic [1:0]  a;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] fmt;

  assign a = alu_q[1:0];

  always_comb begin
    byte_v = data_q[7:0];
    case (a)
      2'd1:    byte_v = data_q[15:8];
      2'd2:    byte_v = data_q[23:16];
      2'd3:    byte_v = data_q[31:24];
      default: byte_v = data_q[7:0];
    endcase
    half_v = a[1] ? data_q[31:16] : data_q[15:0];
    fmt = '0;
    case (op_q)
      LOP_LB:  fmt = {{24{byte_v[7]}}, byte_v};
      LOP_LBU: fmt = {24'd0, byte_v};
      LOP_LH:  fmt = a[0] ? '0 : {{16{half_v[15]}}, half_v};
      LOP_LHU: fmt = a[0] ? '0 : {16'd0, half_v};
      LOP_LW:  fmt = (a == 2'd0) ? data_q : '0;
      LOP_LWL: case (a)
                 2'd0:    fmt = {data_q[7:0], rt_q[23:0]};
                 2'd1:    fmt = {data_q[15:0], rt_q[15:0]};
                 2'd2:    fmt = {data_q[23:0], rt_q[7:0]};
                 default: fmt = data_q;
               endcase
      LOP_LWR: case (a)
                 2'd0:    fmt = data_q;
                 2'd1:    fmt = {rt_q[31:24], data_q[31:8]};
                 2'd2:    fmt = {rt_q[31:16], data_q[31:16]};
                 default: fmt = {rt_q[31:8], data_q[31:24]};
               endcase
      default: fmt = '0;
    endcase
    out_wdata = sel_mem_q ? fmt : alu_q;
  end

  logic int_pend;
  assign int_pend = ((cp0_cause[15:8] & cp0_status[15:8]) != 8'd0) &&
                    !cp0_status[1] && cp0_status[0];

  always_comb begin
    out_excepttype = '0;
    if (valid_q && (pc_q != '0)) begin
      if (int_pend)                  out_excepttype = ET_INT;
      else if (exc_q[EXC_SYSCALL])   out_excepttype = ET_SYSCALL;
      else if (exc_q[EXC_BREAK])     out_excepttype = ET_BREAK;
      else if (exc_q[EXC_RI])        out_excepttype = ET_RI;
      else if (exc_q[EXC_TRAP])      out_excepttype = ET_TRAP;
      else if (exc_q[EXC_OV])        out_excepttype = ET_OV;
      else if (exc_q[EXC_ERET])      out_excepttype = ET_ERET;
      else if (exc_q[EXC_ADES])      out_excepttype = ET_ADES;
      else if (exc_q[EXC_ADEL])      out_excepttype = ET_ADEL;
      else if (exc_q[EXC_IF_ADEL])   out_excepttype = ET_ADEL;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{exc_q[7:0], exc_q[EXC_W-1:17], cp0_status[31:16],
                         cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_we      = we_q;
  assign out_waddr   = waddr_q;
  assign out_data_ok = data_ok_q;
  assign out_epc     = cp0_epc;
  assign out_dslot   = dslot_q;
  assign out_badva   = badva_q;
  assign out_side    = side_q;

endmodule
